imem_uart_loader: RTL and testbench
===================================

Name: imem_uart_loader

Overview:
- Writer side of the instruction memory: streams a program image from the UART byte receiver into the write port of the dual-port program ROM/RAM.
- The fetch path keeps reading the other port.
- Sits between the UART RX block and the instruction memory write port; driven by the boot/download controller via `start`.
- Image format: 16-bit little-endian word count, then count × 4 bytes, each word little-endian.

Parameters:
- ADDR_W, 14, instruction memory word-address width; depth = 2^ADDR_W words.
- BASE_ADDR, 0, word address written by the first image word.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  one-cycle pulse; begins a load.
- rx_valid  input  1  one-cycle strobe; rx_data holds a received byte.
- rx_data  input  8  received byte.
- imem_we  output  1  instruction memory write enable, one cycle per word.
- imem_addr  output  ADDR_W  word address for the write.
- imem_wdata  output  32  word to write.
- busy  output  1  load in progress.
- done  output  1  sticky; load finished, with or without error.
- err  output  1  sticky; image rejected or corrupted.

Behaviour:
- Clocking and reset
  - One clock (clk); asynchronous active-low reset (rst_n).
  - All outputs are registered.
  - On reset: state=IDLE; imem_we=0, imem_addr=0, imem_wdata=0, busy=0, done=0, err=0; byte counter and word counter cleared.
- States: IDLE, LEN_LO, LEN_HI, DATA, CHK (only with the optional feature), DONE.
- IDLE/DONE
  - start → LEN_LO; busy=1; done=0; err=0; counters cleared.
  - rx_valid is ignored in IDLE and DONE.
- LEN_LO: rx_valid → len[7:0] ← rx_data; go to LEN_HI.
- LEN_HI: rx_valid → len[15:8] ← rx_data, then:
  - len==0 → DONE, done=1, busy=0, no writes.
  - BASE_ADDR+len > 2^ADDR_W → DONE, err=1, done=1, busy=0, no writes.
  - otherwise → DATA.
- DATA
  - Byte k of a word (k=0..3) goes to wdata[8k+7:8k].
  - On the 4th byte: imem_we=1 in the next cycle, with imem_addr = BASE_ADDR + word_index and imem_wdata = the assembled word.
  - imem_we is high for exactly one cycle; addr/wdata hold until the next write.
  - word_index increments after each write.
  - After the write for word len-1 → DONE (or CHK). done=1 and busy=0 in the cycle after the last imem_we.
- Timing
  - Bytes may arrive every cycle; no backpressure.
  - A byte arriving in the same cycle as imem_we is accepted into the next word.
- start while busy is ignored.
- rst_n low mid-load aborts immediately:
  - the partial word is dropped;
  - words already written stay in memory;
  - outputs return to reset values.
- Address arithmetic is ADDR_W bits. The overflow check guarantees no wrap within a load.

Optional Feature:
- Macro: IMEM_LOADER_CHECKSUM_EN.
- Defined:
  - Running XOR of all data bytes (length bytes excluded); reset at start.
  - After the last word, state CHK waits for one checksum byte.
  - Equal → done=1, err=0. Mismatch → done=1, err=1 (words remain written).
  - len==0 still expects a checksum byte; the expected value is 0x00.
- Undefined: no CHK state; DONE follows the last write directly; err is set only by the length check.

Test Plan:
- start; bytes 02 00 01 02 03 04 AA BB CC DD → imem_we pulses twice:
  - addr 0, data 0x04030201;
  - addr 1, data 0xDDCCBBAA.
  - Then done=1, busy=0, err=0.
- start; bytes 00 00 → no imem_we, done=1 and err=0 one cycle after the 2nd byte.
- start; bytes 01 40 (len=0x4001) → done=1, err=1, no imem_we; further bytes ignored.
- start; bytes 03 00 plus 6 data bytes; assert rst_n=0 → all outputs 0, only word 0 written. A new start with a full image loads correctly.
- Second start pulse mid-load → ignored: load completes normally, word count unchanged.
- With IMEM_LOADER_CHECKSUM_EN: bytes 01 00 01 02 03 04 04 → done=1, err=0. Same image with trailing byte 05 → done=1, err=1.

Source files
------------

// File: rtl/imem_uart_loader_if.sv
// Byte-stream in / memory-write out bundle for the instruction-memory loader.
// Pure wiring, no latency; no backpressure signals exist on either side.
// Master = boot controller + UART RX + memory side; slave = the loader.
interface imem_uart_loader_if #(parameter int ADDR_W = 14);
    logic              start;
    logic              rx_valid;
    logic [7:0]        rx_data;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;
    logic              busy;
    logic              done;
    logic              err;

    modport master (
        output start, rx_valid, rx_data,
        input  imem_we, imem_addr, imem_wdata, busy, done, err
    );

    modport slave (
        input  start, rx_valid, rx_data,
        output imem_we, imem_addr, imem_wdata, busy, done, err
    );
endinterface

// File: rtl/imem_uart_loader.sv
// Loads a length-prefixed little-endian program image from UART bytes into imem.
// Latency: write one cycle after a word's 4th byte; done one cycle after last write.
// No backpressure: a byte per cycle is accepted; IMEM_LOADER_CHECKSUM_EN adds an XOR trailer.
module imem_uart_loader #(
    parameter int ADDR_W    = 14,
    parameter int BASE_ADDR = 0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    imem_uart_loader_if.slave    bus
);

    typedef enum logic [2:0] {
        IDLE,
        LEN_LO,
        LEN_HI,
        DATA,
`ifdef IMEM_LOADER_CHECKSUM_EN
        CHK,
`endif
        DONE
    } state_t;

    localparam logic [32:0] DEPTH = 33'(1) << ADDR_W;

    state_t            state_q, state_d;
    logic [15:0]       len_q, len_d;
    logic [15:0]       word_cnt_q, word_cnt_d;
    logic [1:0]        byte_cnt_q, byte_cnt_d;
    logic [23:0]       wbuf_q, wbuf_d;
    logic [7:0]        csum_q, csum_d;
    logic              imem_we_q, imem_we_d;
    logic [ADDR_W-1:0] imem_addr_q, imem_addr_d;
    logic [31:0]       imem_wdata_q, imem_wdata_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic [15:0]       len_full;

    always_comb begin
        state_d      = state_q;
        len_d        = len_q;
        word_cnt_d   = word_cnt_q;
        byte_cnt_d   = byte_cnt_q;
        wbuf_d       = wbuf_q;
        csum_d       = csum_q;
        imem_we_d    = 1'b0;
        imem_addr_d  = imem_addr_q;
        imem_wdata_d = imem_wdata_q;
        busy_d       = busy_q;
        done_d       = done_q;
        err_d        = err_q;
        len_full     = {bus.rx_data, len_q[7:0]};

        case (state_q)
            IDLE, DONE: begin
                if (bus.start) begin
                    state_d    = LEN_LO;
                    busy_d     = 1'b1;
                    done_d     = 1'b0;
                    err_d      = 1'b0;
                    byte_cnt_d = 2'd0;
                    word_cnt_d = 16'd0;
                    csum_d     = 8'd0;
                end
            end
            LEN_LO: begin
                if (bus.rx_valid) begin
                    len_d[7:0] = bus.rx_data;
                    state_d    = LEN_HI;
                end
            end
            LEN_HI: begin
                if (bus.rx_valid) begin
                    len_d = len_full;
                    if (len_full == 16'd0) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                        state_d = CHK;
`else
                        state_d = DONE;
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
`endif
                    end else if (33'(len_full) + 33'(BASE_ADDR) > DEPTH) begin
                        state_d = DONE;
                        err_d   = 1'b1;
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                    end else begin
                        state_d = DATA;
                    end
                end
            end
            DATA: begin
                // word_cnt == len means the final write is on the bus this cycle
                if (word_cnt_q == len_q) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                    if (bus.rx_valid) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                        err_d   = (bus.rx_data != csum_q);
                    end else begin
                        state_d = CHK;
                    end
`else
                    state_d = DONE;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
`endif
                end else if (bus.rx_valid) begin
                    csum_d     = csum_q ^ bus.rx_data;
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    case (byte_cnt_q)
                        2'd0: wbuf_d[7:0]   = bus.rx_data;
                        2'd1: wbuf_d[15:8]  = bus.rx_data;
                        2'd2: wbuf_d[23:16] = bus.rx_data;
                        default: begin
                            imem_we_d    = 1'b1;
                            imem_addr_d  = ADDR_W'(BASE_ADDR) + ADDR_W'(word_cnt_q);
                            imem_wdata_d = {bus.rx_data, wbuf_q};
                            word_cnt_d   = word_cnt_q + 16'd1;
                        end
                    endcase
                end
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            CHK: begin
                if (bus.rx_valid) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    err_d   = (bus.rx_data != csum_q);
                end
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            len_q        <= '0;
            word_cnt_q   <= '0;
            byte_cnt_q   <= '0;
            wbuf_q       <= '0;
            csum_q       <= '0;
            imem_we_q    <= 1'b0;
            imem_addr_q  <= '0;
            imem_wdata_q <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            len_q        <= len_d;
            word_cnt_q   <= word_cnt_d;
            byte_cnt_q   <= byte_cnt_d;
            wbuf_q       <= wbuf_d;
            csum_q       <= csum_d;
            imem_we_q    <= imem_we_d;
            imem_addr_q  <= imem_addr_d;
            imem_wdata_q <= imem_wdata_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            err_q        <= err_d;
        end
    end

    assign bus.imem_we    = imem_we_q;
    assign bus.imem_addr  = imem_addr_q;
    assign bus.imem_wdata = imem_wdata_q;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.err        = err_q;

endmodule

// File: tb/tb_imem_uart_loader.sv
// Bench for imem_uart_loader: image-level reference model feeds an expected-write
// queue; an independent monitor pops it on every imem_we. Small ADDR_W exposes the length limit.
module tb_imem_uart_loader;

    localparam int ADDR_W    = 6;
    localparam int BASE_ADDR = 4;
    localparam int DEPTH     = 1 << ADDR_W;

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [31:0]       data;
    } wr_t;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;
    wr_t  exp_q[$];
    wr_t  mon_e;

    imem_uart_loader_if #(.ADDR_W(ADDR_W)) bus ();

    imem_uart_loader #(.ADDR_W(ADDR_W), .BASE_ADDR(BASE_ADDR)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every write strobe must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rst_n && bus.imem_we === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write: got addr %0h data %0h, expected no write",
                         bus.imem_addr, bus.imem_wdata);
            end else begin
                mon_e = exp_q.pop_front();
                chk("wr_addr", 64'(bus.imem_addr), 64'(mon_e.addr));
                chk("wr_data", 64'(bus.imem_wdata), 64'(mon_e.data));
            end
        end
    end

    task automatic idle_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        bus.start = 1'b1;
        idle_cycle();
        bus.start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        bus.rx_valid = 1'b1;
        bus.rx_data  = b;
        idle_cycle();
        bus.rx_valid = 1'b0;
        bus.rx_data  = $urandom_range(0, 255);
    endtask

    task automatic wait_done(input bit exp_err);
        int n;
        n = 0;
        while (bus.done !== 1'b1 && n < 400) begin
            @(negedge clk);
            n++;
        end
        chk("done", 64'(bus.done), 64'd1);
        chk("err", 64'(bus.err), 64'(exp_err));
        chk("busy_idle", 64'(bus.busy), 64'd0);
        chk("pending_writes", 64'(exp_q.size()), 64'd0);
    endtask

    // Reference model at image level: words land at BASE+i, little-endian,
    // unless the image would run past the top of memory.
    task automatic do_load(input int len, input logic [7:0] data[$], input bit corrupt,
                           input bit extra_start, input bit gaps);
        logic [7:0] cs;
        bit         fits;
        bit         exp_err;
        cs      = 8'h00;
        fits    = (BASE_ADDR + len) <= DEPTH;
        exp_err = !fits;
        if (fits) begin
            for (int w = 0; w < len; w++)
                exp_q.push_back('{addr: ADDR_W'(BASE_ADDR + w),
                                  data: {data[4*w+3], data[4*w+2], data[4*w+1], data[4*w]}});
            for (int i = 0; i < data.size(); i++) cs ^= data[i];
`ifdef IMEM_LOADER_CHECKSUM_EN
            exp_err = corrupt;
`endif
        end
        $display("load len=%0d corrupt=%0b extra_start=%0b", len, corrupt, extra_start);
        pulse_start();
        chk("busy_after_start", 64'(bus.busy), 64'd1);
        chk("done_clr_on_start", 64'(bus.done), 64'd0);
        send_byte(len[7:0]);
        send_byte(len[15:8]);
        for (int i = 0; i < data.size(); i++) begin
            if (extra_start && i == 2) pulse_start();
            if (gaps) repeat ($urandom_range(0, 2)) idle_cycle();
            send_byte(data[i]);
        end
`ifdef IMEM_LOADER_CHECKSUM_EN
        if (fits) send_byte(corrupt ? (cs ^ 8'h01) : cs);
`endif
        wait_done(exp_err);
    endtask

    initial begin
        logic [7:0] d[$];
        int         len;
        checks       = 0;
        errors       = 0;
        rst_n        = 1'b0;
        bus.start    = 1'b0;
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_we", 64'(bus.imem_we), 64'd0);
        chk("rst_addr", 64'(bus.imem_addr), 64'd0);
        chk("rst_wdata", 64'(bus.imem_wdata), 64'd0);
        chk("rst_busy", 64'(bus.busy), 64'd0);
        chk("rst_done", 64'(bus.done), 64'd0);
        chk("rst_err", 64'(bus.err), 64'd0);
        rst_n = 1'b1;
        idle_cycle();

        // Bytes ignored while idle.
        send_byte(8'h55);
        idle_cycle();
        chk("idle_busy", 64'(bus.busy), 64'd0);

        d = '{8'h01, 8'h02, 8'h03, 8'h04, 8'hAA, 8'hBB, 8'hCC, 8'hDD};
        do_load(2, d, 1'b0, 1'b0, 1'b0);

        // Zero length: done exactly one cycle after the second length byte.
        pulse_start();
        send_byte(8'h00);
        send_byte(8'h00);
`ifdef IMEM_LOADER_CHECKSUM_EN
        send_byte(8'h00);
`endif
        @(negedge clk);
        chk("len0_done_timing", 64'(bus.done), 64'd1);
        chk("len0_err", 64'(bus.err), 64'd0);

        // Oversized image, then trailing bytes that must be ignored.
        d = '{8'h11, 8'h22, 8'h33, 8'h44};
        do_load(16'h4001, d, 1'b0, 1'b0, 1'b0);
        d = {};
        do_load(DEPTH - BASE_ADDR + 1, d, 1'b0, 1'b0, 1'b0);

        // Exactly filling memory is legal.
        d = {};
        for (int i = 0; i < 4 * (DEPTH - BASE_ADDR); i++) d.push_back($urandom_range(0, 255));
        do_load(DEPTH - BASE_ADDR, d, 1'b0, 1'b0, 1'b0);

        // Reset mid-load: only word 0 survives, outputs return to reset values.
        exp_q.push_back('{addr: ADDR_W'(BASE_ADDR), data: 32'h44332211});
        pulse_start();
        send_byte(8'h03);
        send_byte(8'h00);
        d = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
        for (int i = 0; i < d.size(); i++) send_byte(d[i]);
        idle_cycle();
        rst_n = 1'b0;
        @(negedge clk);
        chk("abort_we", 64'(bus.imem_we), 64'd0);
        chk("abort_addr", 64'(bus.imem_addr), 64'd0);
        chk("abort_wdata", 64'(bus.imem_wdata), 64'd0);
        chk("abort_busy", 64'(bus.busy), 64'd0);
        chk("abort_done", 64'(bus.done), 64'd0);
        chk("abort_writes", 64'(exp_q.size()), 64'd0);
        idle_cycle();
        rst_n = 1'b1;
        idle_cycle();
        d = {};
        for (int i = 0; i < 12; i++) d.push_back($urandom_range(0, 255));
        do_load(3, d, 1'b0, 1'b0, 1'b1);

        // Second start mid-load is ignored.
        d = {};
        for (int i = 0; i < 16; i++) d.push_back($urandom_range(0, 255));
        do_load(4, d, 1'b0, 1'b1, 1'b1);

`ifdef IMEM_LOADER_CHECKSUM_EN
        d = '{8'h01, 8'h02, 8'h03, 8'h04};
        do_load(1, d, 1'b0, 1'b0, 1'b0);
        do_load(1, d, 1'b1, 1'b0, 1'b0);
`endif

        // Randomized images.
        for (int t = 0; t < 12; t++) begin
            len = $urandom_range(1, 10);
            d = {};
            for (int i = 0; i < 4 * len; i++) d.push_back($urandom_range(0, 255));
            do_load(len, d, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 1)));
        end

        repeat (3) idle_cycle();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
